// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
//
// Pipeline-stage register with a valid/ready handshake, an optional 2-entry
// skid buffer, flush, and bubble insertion. It replaces a fixed stall/flush
// stage register between core pipeline stages. The payload is an arbitrary
// packed vector, such as {instr, pc, pc_plus4}.
//
// Handshake: a transfer happens on a port in any cycle where its valid and
// ready are both 1 at the rising edge. A producer holds valid and data stable
// until the transfer. Ready may depend on state only (SKID=1) or also on
// out_ready (SKID=0). Data is only meaningful while valid is 1.
//
// Parameters
//   DATA_W  payload width in bits
//   SKID    1: 2-entry skid buffer, in_ready is taken from a register
//           0: single entry, in_ready = !full | out_ready (combinational)
//   BUBBLE  value shown on out_data whenever out_valid is 0
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset (takes priority over flush)
//   flush      discard every held entry and any in_data offered this cycle
//   in_valid   upstream offers in_data
//   in_ready   stage accepts in_data this cycle
//   in_data    upstream payload
//   out_valid  out_data holds a valid entry
//   out_ready  downstream accepts out_data this cycle
//   out_data   head entry, or BUBBLE when empty
//   count      entries held (0..2)
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
    parameter int                DATA_W = 160,
    parameter int                SKID   = 1,
    parameter logic [DATA_W-1:0] BUBBLE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    // Main entry (M) drives the output; skid entry (S) catches the one
    // extra word that arrives while in_ready is still registered high.
    logic              m_valid, m_valid_n;
    logic [DATA_W-1:0] m_data,  m_data_n;
    logic              s_valid, s_valid_n;
    logic [DATA_W-1:0] s_data,  s_data_n;

    logic in_fire;
    logic out_fire;

    // With a skid buffer in_ready comes straight from a flop, which breaks
    // the combinational ready chain between stages.
    assign in_ready  = (SKID != 0) ? !s_valid : (!m_valid || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = m_valid && out_ready;

    assign out_valid = m_valid;
    // M's data register holds BUBBLE whenever M is empty, so no mux needed.
    assign out_data  = m_data;
    assign count     = {1'b0, m_valid} + {1'b0, s_valid};

    always_comb begin
        m_valid_n = m_valid;
        m_data_n  = m_data;
        s_valid_n = s_valid;
        s_data_n  = s_data;

        if (flush) begin
            // Flush overrides every transfer, including an in-fire this cycle.
            m_valid_n = 1'b0;
            m_data_n  = BUBBLE;
            s_valid_n = 1'b0;
            s_data_n  = BUBBLE;
        end else if (SKID != 0) begin
            if (s_valid) begin
                // in_ready is 0 here, so only the S -> M move can happen.
                if (out_fire) begin
                    m_data_n  = s_data;
                    s_valid_n = 1'b0;
                    s_data_n  = BUBBLE;
                end
            end else if (!m_valid) begin
                if (in_fire) begin
                    m_valid_n = 1'b1;
                    m_data_n  = in_data;
                end
            end else begin
                case ({out_fire, in_fire})
                    2'b11: m_data_n = in_data;
                    2'b10: begin
                        m_valid_n = 1'b0;
                        m_data_n  = BUBBLE;
                    end
                    2'b01: begin
                        // Downstream stalled: park the new word in S.
                        s_valid_n = 1'b1;
                        s_data_n  = in_data;
                    end
                    default: ;
                endcase
            end
        end else begin
            if (in_fire) begin
                m_valid_n = 1'b1;
                m_data_n  = in_data;
            end else if (out_fire) begin
                m_valid_n = 1'b0;
                m_data_n  = BUBBLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= BUBBLE;
            s_valid <= 1'b0;
            s_data  <= BUBBLE;
        end else begin
            m_valid <= m_valid_n;
            m_data  <= m_data_n;
            s_valid <= s_valid_n;
            s_data  <= s_data_n;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid
//
// Two instances share one set of inputs: u_skid (SKID=1, BUBBLE=0x13) and
// u_flat (SKID=0, BUBBLE=0). `sel` picks which one is being checked.
// Each cycle, inputs are driven just after the rising edge and outputs are
// sampled on the falling edge. A FIFO model (exp_q) holds the entries the
// stage should contain. Entries are pushed on in-fire, popped and compared on
// out-fire, and cleared on flush/rst.
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid;

    localparam int DW = 160;
    localparam logic [DW-1:0] BUB1 = 160'h13;
    localparam logic [DW-1:0] BUB0 = '0;

    // Clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;

    logic          ir1, ov1, ir0, ov0;
    logic [DW-1:0] od1, od0;
    logic [1:0]    cnt1, cnt0;

    pipe_stage_skid #(.DATA_W(DW), .SKID(1), .BUBBLE(BUB1)) u_skid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .count(cnt1)
    );

    pipe_stage_skid #(.DATA_W(DW), .SKID(0)) u_flat (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .count(cnt0)
    );

    bit            sel = 1'b1;
    logic          cur_ir, cur_ov;
    logic [DW-1:0] cur_od, cur_bub;
    logic [1:0]    cur_cnt;
    always_comb begin
        cur_ir  = sel ? ir1  : ir0;
        cur_ov  = sel ? ov1  : ov0;
        cur_od  = sel ? od1  : od0;
        cur_cnt = sel ? cnt1 : cnt0;
        cur_bub = sel ? BUB1 : BUB0;
    end

    // Scoreboard state and counters
    logic [DW-1:0] exp_q[$];
    int n_vec  = 0;
    int n_err  = 0;

    typedef struct {
        bit            rst;
        bit            flush;
        bit            iv;
        logic [DW-1:0] id;
        bit            ordy;
        bit            eov;
        logic [DW-1:0] eod;
        logic [1:0]    ecnt;
        bit            eir;
    } vec_t;

    function automatic vec_t mk(bit r, bit f, bit iv, logic [31:0] d, bit ordy,
                                bit eov, logic [31:0] eod, logic [1:0] ec, bit eir);
        vec_t v;
        v.rst   = r;
        v.flush = f;
        v.iv    = iv;
        v.id    = {{(DW-32){1'b0}}, d};
        v.ordy  = ordy;
        v.eov   = eov;
        v.eod   = {{(DW-32){1'b0}}, eod};
        v.ecnt  = ec;
        v.eir   = eir;
        return v;
    endfunction

    task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s sel=%0d t=%0t: got %0h expected %0h", nm, sel, $time, act, exp);
        end
    endtask

    // One cycle: drive, sample at negedge, check, update the model.
    task automatic cycle(bit use_exp, vec_t v);
        logic [DW-1:0] head;
        rst       = v.rst;
        flush     = v.flush;
        in_valid  = v.iv;
        in_data   = v.id;
        out_ready = v.ordy;
        @(negedge clk);
        if (use_exp) begin
            chk("tab_out_valid", DW'(cur_ov),  DW'(v.eov));
            chk("tab_out_data",  cur_od,       v.eod);
            chk("tab_count",     DW'(cur_cnt), DW'(v.ecnt));
            chk("tab_in_ready",  DW'(cur_ir),  DW'(v.eir));
        end
        // FIFO-model view of the stage
        head = (exp_q.size() != 0) ? exp_q[0] : cur_bub;
        chk("mdl_count",     DW'(cur_cnt), DW'(exp_q.size()));
        chk("mdl_out_valid", DW'(cur_ov),  DW'(exp_q.size() != 0));
        chk("mdl_out_data",  cur_od,       head);
        if (sel) chk("mdl_in_ready", DW'(cur_ir), DW'(exp_q.size() < 2));
        else     chk("mdl_in_ready", DW'(cur_ir), DW'((exp_q.size() == 0) || out_ready));
        // Scoreboard: pop on out-fire, clear on flush/rst, push on in-fire
        if (cur_ov && out_ready && !rst) begin
            if (exp_q.size() == 0) chk("sb_underflow", DW'(1), DW'(0));
            else chk("sb_order", cur_od, exp_q.pop_front());
        end
        if (rst || flush) exp_q.delete();
        else if (in_valid && cur_ir) exp_q.push_back(in_data);
        @(posedge clk);
        #1;
    endtask

    vec_t t1[$];
    vec_t t0[$];
    int   seq;

    initial begin
        // SKID=1 table (BUBBLE = 0x13)
        // r f iv data ordy | ov od cnt ir
        t1.push_back(mk(1,0,0,'h0 ,0, 0,'h13,0,1));  // reset state
        for (int i = 1; i <= 8; i++)                 // streaming 1..8
            t1.push_back(mk(0,0,1,i,1, (i>1),(i>1)?i-1:'h13,(i>1)?1:0,1));
        t1.push_back(mk(0,0,0,'h0 ,1, 1,'h8 ,1,1));
        t1.push_back(mk(0,0,0,'h0 ,0, 0,'h13,0,1));  // bubble after drain
        t1.push_back(mk(0,0,1,'h10,1, 0,'h13,0,1));  // backpressure
        t1.push_back(mk(0,0,1,'h11,0, 1,'h10,1,1));
        t1.push_back(mk(0,0,1,'h12,0, 1,'h10,2,0));
        t1.push_back(mk(0,0,1,'h12,0, 1,'h10,2,0));
        t1.push_back(mk(0,0,1,'h12,1, 1,'h10,2,0));  // S -> M
        t1.push_back(mk(0,0,1,'h12,1, 1,'h11,1,1));  // upstream fires again
        t1.push_back(mk(0,0,0,'h0 ,1, 1,'h12,1,1));
        t1.push_back(mk(0,0,0,'h0 ,0, 0,'h13,0,1));
        t1.push_back(mk(0,0,1,'h20,0, 0,'h13,0,1));  // flush with count 2
        t1.push_back(mk(0,0,1,'h21,0, 1,'h20,1,1));
        t1.push_back(mk(0,1,1,'h55,0, 1,'h20,2,0));
        t1.push_back(mk(0,0,0,'h0 ,0, 0,'h13,0,1));
        t1.push_back(mk(0,1,1,'h56,1, 0,'h13,0,1));  // flush beats in-fire
        t1.push_back(mk(0,0,0,'h0 ,0, 0,'h13,0,1));
        t1.push_back(mk(0,0,1,'h30,1, 0,'h13,0,1));  // out-fire in flush cycle
        t1.push_back(mk(0,1,0,'h0 ,1, 1,'h30,1,1));
        t1.push_back(mk(0,0,0,'h0 ,0, 0,'h13,0,1));
        t1.push_back(mk(0,0,1,'h40,0, 0,'h13,0,1));  // reset mid-operation
        t1.push_back(mk(0,0,1,'h41,0, 1,'h40,1,1));
        t1.push_back(mk(1,1,1,'h66,0, 1,'h40,2,0));
        t1.push_back(mk(0,0,1,'hA ,0, 0,'h13,0,1));
        t1.push_back(mk(0,0,0,'h0 ,1, 1,'hA ,1,1));
        t1.push_back(mk(0,0,0,'h0 ,0, 0,'h13,0,1));

        // SKID=0 table (BUBBLE = 0)
        t0.push_back(mk(1,0,0,'h0 ,0, 0,'h0,0,1));
        t0.push_back(mk(0,0,1,'h6 ,0, 0,'h0,0,1));
        t0.push_back(mk(0,0,1,'h7 ,0, 1,'h6,1,0));   // full, stalled
        t0.push_back(mk(0,0,1,'h7 ,1, 1,'h6,1,1));   // ready follows out_ready
        t0.push_back(mk(0,0,0,'h0 ,0, 1,'h7,1,0));
        t0.push_back(mk(0,0,0,'h0 ,1, 1,'h7,1,1));
        t0.push_back(mk(0,0,0,'h0 ,0, 0,'h0,0,1));
        t0.push_back(mk(0,0,1,'h8 ,0, 0,'h0,0,1));
        t0.push_back(mk(0,1,1,'h55,0, 1,'h8,1,0));
        t0.push_back(mk(0,0,1,'h9 ,1, 0,'h0,0,1));
        t0.push_back(mk(0,0,0,'h0 ,0, 1,'h9,1,0));
        t0.push_back(mk(0,1,1,'h56,1, 1,'h9,1,1));
        t0.push_back(mk(0,0,0,'h0 ,0, 0,'h0,0,1));

        // Initial reset edge, unchecked (state is unknown before it)
        @(posedge clk);
        #1;

        sel = 1'b1;
        exp_q.delete();
        foreach (t1[i]) cycle(1'b1, t1[i]);

        // Random traffic on the skid stage against the FIFO model
        seq = 'h100;
        for (int i = 0; i < 400; i++) begin
            cycle(1'b0, mk(0, ($urandom_range(0, 31) == 0), $urandom_range(0, 1), seq,
                           ($urandom_range(0, 3) != 0), 0, 0, 0, 0));
            seq++;
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, mk(0,0,0,0,1,0,0,0,0));
        chk("skid_drained", DW'(exp_q.size()), DW'(0));

        sel = 1'b0;
        exp_q.delete();
        foreach (t0[i]) cycle(1'b1, t0[i]);

        seq = 'h800;
        for (int i = 0; i < 300; i++) begin
            cycle(1'b0, mk(0, ($urandom_range(0, 31) == 0), $urandom_range(0, 1), seq,
                           ($urandom_range(0, 2) != 0), 0, 0, 0, 0));
            seq++;
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, mk(0,0,0,0,1,0,0,0,0));
        chk("flat_drained", DW'(exp_q.size()), DW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline-stage register with a valid/ready handshake, an optional 2-entry skid buffer, flush, and bubble insertion. It generalises the fixed-width stall/flush stage registers between core pipeline stages (IF/ID, ID/EX, ...). Each instance carries an arbitrary packed payload, such as {instr, PC, PC+4}. Backpressure replaces the external stall input, and a registered `in_ready` breaks the combinational ready path between stages.

## Interface
Parameters:
- `DATA_W`, 160, payload width in bits (≥1).
- `SKID`, 1: 1 = 2-entry skid buffer with registered `in_ready`; 0 = single entry with combinational `in_ready`.
- `BUBBLE`, `'0`, `DATA_W`-bit value driven on `out_data` whenever `out_valid`=0 (for example, a NOP encoding in the instruction field).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  discard all held entries this cycle.
- `in_valid`  in  1  upstream presents `in_data`.
- `in_ready`  out  1  stage accepts `in_data` this cycle.
- `in_data`  in  `DATA_W`  upstream payload.
- `out_valid`  out  1  `out_data` holds a valid entry.
- `out_ready`  in  1  downstream accepts `out_data` this cycle.
- `out_data`  out  `DATA_W`  head entry, or `BUBBLE` when not valid.
- `count`  out  2  entries held (0..2; 0..1 when `SKID`=0).

## Operation
- A transfer happens on a port when its valid and ready are both 1 in the same cycle: in-fire = `in_valid & in_ready`; out-fire = `out_valid & out_ready`.
- Storage:
  - Main register (M) drives `out_data`.
  - Skid register (S) exists only when `SKID`=1.
  - Each has a valid bit.
- Strict FIFO order. No entry is dropped or duplicated except by `flush` or `rst`.
- `SKID`=1:
  - `in_ready` = !S.valid, taken from the register.
  - M empty, in-fire: M ← `in_data`.
  - M full, out-fire, in-fire: M ← `in_data`.
  - M full, no out-fire, in-fire: S ← `in_data`, and `in_ready` goes to 0 next cycle.
  - S full, out-fire: M ← S, S is emptied, and `in_ready` goes to 1 next cycle. No in-fire is possible in this cycle.
  - M full, out-fire, no in-fire, S empty: M is emptied.
- `SKID`=0:
  - `in_ready` = !M.valid | `out_ready`, purely combinational.
  - in-fire loads M. Out-fire without in-fire empties M.
- Flush:
  - Clears M.valid and S.valid.
  - Data registers are set to `BUBBLE`.
  - An `in_valid` arriving in the flush cycle is discarded, even if `in_ready`=1.
  - Flush takes priority over every transfer rule.
  - If `out_valid`=1 in the flush cycle, downstream may still sample it (its own out-fire). The stage discards the entry regardless.
- Reset gives the same state as flush. `rst` has priority over `flush`.
- `count` = M.valid + S.valid.
- When M is idle, `out_data` = `BUBBLE`. M's data register is written `BUBBLE` whenever M becomes empty.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=`BUBBLE`, `count`=0.
  - `in_ready`=1, from the cycle after `rst` is sampled high.
  - While `rst`=1, `in_ready` = registered value; it is 1 after the first reset edge.
- Latency: in-fire at edge N makes `out_valid`=1 and `out_data`= that payload after edge N.
- Throughput: one transfer per cycle when `out_ready` is held at 1. With `SKID`=1 the skid never fills in that case.
- After `out_ready` deasserts with a full stream, exactly one extra entry is absorbed into S. `in_ready` is 0 in the following cycle.
- After `out_ready` reasserts:
  - Edge 1: S moves to M.
  - Edge 2: upstream may fire again, since `in_ready` returned to 1 after edge 1.
- Flush or reset mid-stream: `out_valid`=0 and `count`=0 after the edge. The next in-fire is allowed in the following cycle.
- `out_valid` and `out_data` never change while `out_valid`=1 and `out_ready`=0, except on flush or rst.

## Test plan
- Streaming: `SKID`=1, `DATA_W`=160, `out_ready`=1, push 0x1..0x8 back-to-back → `out_data` shows 0x1..0x8 one cycle behind input, no gaps, `count` ≤1.
- Backpressure: 0x10, 0x11, 0x12 pushed; `out_ready`=0 from the second cycle → M=0x10, S=0x11, `in_ready`=0, 0x12 held upstream. Release `out_ready` → outputs appear in the order 0x10, 0x11, 0x12, and `count` goes 2→1→…
- Flush: `count`=2, assert `flush` with `in_valid`=1 and data 0x55 → next cycle `out_valid`=0, `out_data`=`BUBBLE`, `count`=0, `in_ready`=1. 0x55 never appears.
- Reset mid-operation: `count`=2, `rst`=1 together with `flush`=1 and `in_valid`=1 → same state as reset. Then push 0xA → appears next cycle.
- `SKID`=0: `out_ready`=0 and M full → `in_ready`=0 in the same cycle. Raise `out_ready` with `in_valid` data 0x7 → `in_ready`=1 combinationally, and M=0x7 next cycle.
- Bubble: `BUBBLE`=0x13 (NOP) in the low bits, idle → `out_data`=0x13 while `out_valid`=0. Must also hold after a drain to empty.
